riscv_writeback: RTL and testbench
==================================

# riscv_writeback

Writeback stage of the RISC-V core pipeline, the writer for `riscv_regfile`. It registers the MEM-stage result and performs load-data extraction with sign/zero extension. It selects the write-back source and drives the regfile write port (`AddrD`, `DataD`, `RegWEn`). It also exports a forwarding tap and a retired-instruction counter.

## Interface
- `XLEN`, 32: data path width; only 32 is supported.
- `clk_i  in  1`: core clock; all state updates on the rising edge.
- `rst_i  in  1`: asynchronous, active-high reset.
- `valid_i  in  1`: the MEM stage holds a real instruction this cycle.
- `stall_i  in  1`: pipeline stall; the upstream stage holds its instruction.
- `flush_i  in  1`: kill the instruction presented this cycle.
- `RegWEn_i  in  1`: the instruction writes a destination register.
- `AddrD_i  in  5`: destination register index.
- `WBSel_i  in  2`: write-back source. 00 = load data, 01 = ALU result, 10 = PC+4, 11 = reserved (writes 0).
- `Funct3_i  in  3`: load type. 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; any other value is treated as LW.
- `ALURes_i  in  32`: ALU result; it is also the load byte address.
- `MemData_i  in  32`: raw aligned 32-bit word from data memory.
- `PC_i  in  32`: instruction PC.
- `AddrD_o  out  5`: regfile write address.
- `DataD_o  out  32`: regfile write data.
- `RegWEn_o  out  1`: regfile write enable.
- `FwdValid_o  out  1`: forwarding tap valid; equals `RegWEn_o`.
- `FwdAddr_o  out  5`: forwarding tap address; equals `AddrD_o`.
- `FwdData_o  out  32`: forwarding tap data; equals `DataD_o`.
- `InstRet_o  out  32`: count of retired instructions.

## Operation
- **Capture condition:** capture = `valid_i & ~stall_i & ~flush_i`, evaluated at each rising edge.
- **On capture:**
  - `AddrD_o` <= `AddrD_i`.
  - `DataD_o` <= selected data.
  - `RegWEn_o` <= `RegWEn_i & (AddrD_i != 0)`.
  - `InstRet_o` <= `InstRet_o + 1`.
- **No capture (bubble):**
  - `RegWEn_o` <= 0.
  - `AddrD_o` and `DataD_o` keep their previous values.
  - `InstRet_o` is unchanged.
- **Stall and flush:** `stall_i` and `flush_i` both produce a bubble; their relative priority is irrelevant. A stalled instruction is captured on the first edge where `stall_i` is low.
- **Load extraction:** byte lane b = `ALURes_i[1:0]`; halfword lane h = `ALURes_i[1]`.
  - LB: `MemData_i[8b+7:8b]`, sign-extended.
  - LBU: `MemData_i[8b+7:8b]`, zero-extended.
  - LH: `MemData_i[16h+15:16h]`, sign-extended.
  - LHU: `MemData_i[16h+15:16h]`, zero-extended.
  - LW: the full word; `ALURes_i[1:0]` is ignored.
  - `ALURes_i[0]` is ignored for halfword loads. Misalignment is not trapped here.
- **Source select:**
  - PC+4 is computed modulo 2^32; `PC_i` = 0xFFFFFFFC gives 0x00000000.
  - The reserved `WBSel_i` value 11 writes 0x00000000.
- **x0 writes:** a write to x0 never asserts `RegWEn_o`. The instruction still counts as retired. `DataD_o` still updates.
- **Retire counter:** `InstRet_o` wraps from 0xFFFFFFFF to 0 with no flag.
- **Forwarding:** the `Fwd*` outputs are direct copies of the registered write port. The decode/EX bypass compares `FwdAddr_o` against its source registers when `FwdValid_o` = 1.

## Timing
- **Reset:** while `rst_i` is asserted, all outputs are 0 immediately (asynchronous): `RegWEn_o`, `AddrD_o`, `DataD_o`, `FwdValid_o`, `FwdAddr_o`, `FwdData_o` and `InstRet_o`.
- **Reset mid-operation:** reset drops any in-flight write. No write pulse is generated on reset deassertion. The first capture can occur on the first rising edge after `rst_i` falls.
- **Latency:** inputs are sampled at edge N. `RegWEn_o`, `AddrD_o` and `DataD_o` are valid from N until N+1. The regfile commits the data at edge N+1.
- **Write enable width:** `RegWEn_o` is high for exactly one cycle per captured writing instruction.
- **Back-to-back:** back-to-back captures give one write per cycle with no dead cycle.
- **Outputs:** all outputs are registered. There is no combinational path from inputs to outputs.
- **Counter timing:** `InstRet_o` updates on the same edge as the capture it counts.

## Test plan
- **Reset and ALU write:** hold `rst_i` high for 21 ns, then present ALU write x5 = 0x12345678 (`WBSel_i`=01, `RegWEn_i`=1). Expect all outputs 0 during reset. One edge after capture expect `RegWEn_o`=1, `AddrD_o`=5, `DataD_o`=0x12345678, `InstRet_o`=1.
- **Loads:** with `MemData_i`=0x80FF7F01, check each load type and lane:
  - LB lane 3 -> 0xFFFFFF80.
  - LBU lane 1 -> 0x0000007F.
  - LH h=1 -> 0xFFFF80FF.
  - LHU h=0 -> 0x00007F01.
  - LW -> 0x80FF7F01.
  - `Funct3_i`=111 -> 0x80FF7F01.
- **PC+4 and reserved select:** `PC_i`=0x00000100 with `WBSel_i`=10 -> `DataD_o`=0x00000104. `PC_i`=0xFFFFFFFC -> 0x00000000. `WBSel_i`=11 -> 0x00000000.
- **x0 write:** write x0 = 0xDEADBEEF -> `RegWEn_o`=0, `FwdValid_o`=0, `DataD_o`=0xDEADBEEF, `InstRet_o` increments.
- **Stall and flush:** valid writes x7 with `stall_i`=1 for 2 cycles, then 0.
  - Expect `RegWEn_o`=0 for 2 cycles, then a single 1-cycle pulse; `InstRet_o` +1 only once.
  - Repeat with `flush_i`=1: no pulse, no increment.
- **Async reset mid-operation and counter wrap:** assert `rst_i` mid-cycle during a write pulse; expect all outputs 0 before the next edge. Then preload the counter to 0xFFFFFFFF via 2^32-1 captures, or force it in the bench; one more capture must give `InstRet_o`=0.

Source files
------------

// File: rtl/riscv_writeback.sv
// riscv_writeback -- writeback stage of the RISC-V core pipeline.
//
// Registers the MEM-stage result, extracts load data (byte/halfword/word
// with sign or zero extension), selects the write-back source and drives
// the regfile write port. Also exports a forwarding tap that mirrors the
// write port and a retired-instruction counter.
//
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   valid_i             MEM stage holds a real instruction
//   stall_i, flush_i    either one turns this cycle into a bubble
//   RegWEn_i, AddrD_i   destination write request and register index
//   WBSel_i             00 load, 01 ALU, 10 PC+4, 11 reserved (zero)
//   Funct3_i            load type (LB/LH/LW/LBU/LHU, others act as LW)
//   ALURes_i            ALU result, also the load byte address
//   MemData_i           aligned 32-bit word read from data memory
//   PC_i                instruction PC
//   AddrD_o/DataD_o/RegWEn_o   regfile write port (registered)
//   FwdValid_o/FwdAddr_o/FwdData_o  forwarding tap, copies of the write port
//   InstRet_o           retired-instruction count, wraps silently
module riscv_writeback #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic            RegWEn_i,
  input  logic [4:0]      AddrD_i,
  input  logic [1:0]      WBSel_i,
  input  logic [2:0]      Funct3_i,
  input  logic [XLEN-1:0] ALURes_i,
  input  logic [XLEN-1:0] MemData_i,
  input  logic [XLEN-1:0] PC_i,
  output logic [4:0]      AddrD_o,
  output logic [XLEN-1:0] DataD_o,
  output logic            RegWEn_o,
  output logic            FwdValid_o,
  output logic [4:0]      FwdAddr_o,
  output logic [XLEN-1:0] FwdData_o,
  output logic [XLEN-1:0] InstRet_o
);

  // Pick the addressed byte/halfword lane and extend it to a full word.
  // The word is shifted down so the addressed lane sits at bit 0.
  function automatic logic [XLEN-1:0] extractLoad(
    input logic [2:0]      funct3,
    input logic [1:0]      lane,
    input logic [XLEN-1:0] word
  );
    logic [XLEN-1:0]   byteShift;
    logic [XLEN-1:0]   halfShift;
    logic signed [7:0]  byteVal;
    logic signed [15:0] halfVal;
    byteShift = word >> {lane, 3'b000};
    halfShift = word >> {lane[1], 4'b0000};
    byteVal   = byteShift[7:0];
    halfVal   = halfShift[15:0];
    case (funct3)
      3'b000:  extractLoad = {{(XLEN-8){byteVal[7]}}, byteVal};
      3'b100:  extractLoad = {{(XLEN-8){1'b0}}, byteVal};
      3'b001:  extractLoad = {{(XLEN-16){halfVal[15]}}, halfVal};
      3'b101:  extractLoad = {{(XLEN-16){1'b0}}, halfVal};
      default: extractLoad = word;
    endcase
  endfunction

  logic            capture;
  logic [XLEN-1:0] loadData;
  logic [XLEN-1:0] selData;

  logic            regWEn_p0;
  logic [4:0]      addrD_p0;
  logic [XLEN-1:0] dataD_p0;
  logic [XLEN-1:0] instRet_p0;

  // Stage 0: source selection (combinational, feeds the output register)
  assign capture  = valid_i & ~stall_i & ~flush_i;
  assign loadData = extractLoad(Funct3_i, ALURes_i[1:0], MemData_i);

  always_comb begin
    selData = '0;
    case (WBSel_i)
      2'b00:   selData = loadData;
      2'b01:   selData = ALURes_i;
      2'b10:   selData = PC_i + XLEN'(4);
      default: selData = '0;
    endcase
  end

  // Stage 0 -> outputs: write-port register; bubbles only drop the enable
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      regWEn_p0  <= 1'b0;
      addrD_p0   <= '0;
      dataD_p0   <= '0;
      instRet_p0 <= '0;
    end else if (capture) begin
      regWEn_p0  <= RegWEn_i & (AddrD_i != 5'd0);
      addrD_p0   <= AddrD_i;
      dataD_p0   <= selData;
      instRet_p0 <= instRet_p0 + XLEN'(1);
    end else begin
      regWEn_p0  <= 1'b0;
    end
  end

  assign RegWEn_o   = regWEn_p0;
  assign AddrD_o    = addrD_p0;
  assign DataD_o    = dataD_p0;
  assign InstRet_o  = instRet_p0;
  assign FwdValid_o = regWEn_p0;
  assign FwdAddr_o  = addrD_p0;
  assign FwdData_o  = dataD_p0;

endmodule

// File: tb/tb_riscv_writeback.sv
module tb_riscv_writeback;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i, stall_i, flush_i, RegWEn_i;
  logic [4:0]  AddrD_i;
  logic [1:0]  WBSel_i;
  logic [2:0]  Funct3_i;
  logic [31:0] ALURes_i, MemData_i, PC_i;
  logic [4:0]  AddrD_o, FwdAddr_o;
  logic [31:0] DataD_o, FwdData_o, InstRet_o;
  logic        RegWEn_o, FwdValid_o;

  int testCnt = 0;
  int failCnt = 0;

  // reference state of the write port
  logic        mWEn;
  logic [4:0]  mAddr;
  logic [31:0] mData;
  logic [31:0] mCnt;

  riscv_writeback #(.XLEN(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .stall_i(stall_i),
    .flush_i(flush_i), .RegWEn_i(RegWEn_i), .AddrD_i(AddrD_i),
    .WBSel_i(WBSel_i), .Funct3_i(Funct3_i), .ALURes_i(ALURes_i),
    .MemData_i(MemData_i), .PC_i(PC_i), .AddrD_o(AddrD_o),
    .DataD_o(DataD_o), .RegWEn_o(RegWEn_o), .FwdValid_o(FwdValid_o),
    .FwdAddr_o(FwdAddr_o), .FwdData_o(FwdData_o), .InstRet_o(InstRet_o)
  );

  always #5 clk_i = ~clk_i;

  // Load extraction from the rules: pick lane by arithmetic, extend by value.
  function automatic logic [31:0] refLoad(input logic [2:0] f3,
                                          input logic [31:0] addr,
                                          input logic [31:0] mem);
    logic [31:0] b, h;
    b = (mem >> (8 * (addr % 4))) % 256;
    h = (mem >> (16 * ((addr / 2) % 2))) % 65536;
    case (f3)
      3'b000:  return (b >= 128) ? b - 32'd256 : b;
      3'b100:  return b;
      3'b001:  return (h >= 32768) ? h - 32'd65536 : h;
      3'b101:  return h;
      default: return mem;
    endcase
  endfunction

  function automatic logic [31:0] refData();
    case (WBSel_i)
      2'd0:    return refLoad(Funct3_i, ALURes_i, MemData_i);
      2'd1:    return ALURes_i;
      2'd2:    return PC_i + 32'd4;
      default: return 32'd0;
    endcase
  endfunction

  task automatic modelEdge();
    if (valid_i && !stall_i && !flush_i) begin
      mWEn  = RegWEn_i && (AddrD_i != 0);
      mAddr = AddrD_i;
      mData = refData();
      mCnt  = mCnt + 1;
    end else begin
      mWEn = 1'b0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    testCnt++;
    assert (obs === exp) else begin
      failCnt++;
      $error("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag);
    chk({tag, ".RegWEn"},   {31'd0, RegWEn_o},   {31'd0, mWEn});
    chk({tag, ".AddrD"},    {27'd0, AddrD_o},    {27'd0, mAddr});
    chk({tag, ".DataD"},    DataD_o,             mData);
    chk({tag, ".FwdValid"}, {31'd0, FwdValid_o}, {31'd0, mWEn});
    chk({tag, ".FwdAddr"},  {27'd0, FwdAddr_o},  {27'd0, mAddr});
    chk({tag, ".FwdData"},  FwdData_o,           mData);
    chk({tag, ".InstRet"},  InstRet_o,           mCnt);
  endtask

  task automatic modelReset();
    mWEn = 0; mAddr = 0; mData = 0; mCnt = 0;
  endtask

  // inputs are set at the falling edge; this advances one rising edge
  task automatic cycle(input string tag);
    @(posedge clk_i);
    modelEdge();
    #1 checkAll(tag);
    @(negedge clk_i);
  endtask

  task automatic setInst(input logic v, input logic we, input logic [4:0] rd,
                         input logic [1:0] sel, input logic [2:0] f3,
                         input logic [31:0] alu, input logic [31:0] mem,
                         input logic [31:0] pc);
    valid_i = v; RegWEn_i = we; AddrD_i = rd; WBSel_i = sel;
    Funct3_i = f3; ALURes_i = alu; MemData_i = mem; PC_i = pc;
  endtask

  initial begin
    rst_i = 1'b1; stall_i = 0; flush_i = 0;
    setInst(0, 0, 0, 0, 0, 0, 0, 0);
    modelReset();

    // reset held for 21 ns
    #10 checkAll("reset");
    #11 rst_i = 1'b0;
    @(negedge clk_i);

    // ALU write x5
    setInst(1, 1, 5'd5, 2'b01, 3'b010, 32'h12345678, 0, 0);
    cycle("alu");
    chk("alu.const", DataD_o, 32'h12345678);
    chk("alu.cnt",   InstRet_o, 32'd1);
    chk("alu.we",    {31'd0, RegWEn_o}, 32'd1);

    // loads from 0x80FF7F01
    setInst(1, 1, 5'd6, 2'b00, 3'b000, 32'h00001003, 32'h80FF7F01, 0);
    cycle("lb3");  chk("lb3.const", DataD_o, 32'hFFFFFF80);
    Funct3_i = 3'b100; ALURes_i = 32'h00002001;
    cycle("lbu1"); chk("lbu1.const", DataD_o, 32'h0000007F);
    Funct3_i = 3'b001; ALURes_i = 32'h00000003;
    cycle("lh1");  chk("lh1.const", DataD_o, 32'hFFFF80FF);
    Funct3_i = 3'b101; ALURes_i = 32'h00000001;
    cycle("lhu0"); chk("lhu0.const", DataD_o, 32'h00007F01);
    Funct3_i = 3'b010; ALURes_i = 32'h00000003;
    cycle("lw");   chk("lw.const", DataD_o, 32'h80FF7F01);
    Funct3_i = 3'b111;
    cycle("f3_7"); chk("f3_7.const", DataD_o, 32'h80FF7F01);

    // PC+4 and reserved select
    setInst(1, 1, 5'd9, 2'b10, 3'b010, 32'h55555555, 0, 32'h00000100);
    cycle("pc4");    chk("pc4.const", DataD_o, 32'h00000104);
    PC_i = 32'hFFFFFFFC;
    cycle("pcwrap"); chk("pcwrap.const", DataD_o, 32'h00000000);
    WBSel_i = 2'b11; ALURes_i = 32'hFFFFFFFF;
    cycle("rsvd");   chk("rsvd.const", DataD_o, 32'h00000000);

    // x0 write
    setInst(1, 1, 5'd0, 2'b01, 3'b010, 32'hDEADBEEF, 0, 0);
    cycle("x0");
    chk("x0.we",   {31'd0, RegWEn_o}, 32'd0);
    chk("x0.data", DataD_o, 32'hDEADBEEF);

    // stall for two cycles, then release
    setInst(1, 1, 5'd7, 2'b01, 3'b010, 32'h0BADF00D, 0, 0);
    stall_i = 1;
    cycle("stall1"); cycle("stall2");
    chk("stall.we", {31'd0, RegWEn_o}, 32'd0);
    stall_i = 0;
    cycle("stallRel");
    chk("stallRel.we", {31'd0, RegWEn_o}, 32'd1);
    valid_i = 0;
    cycle("stallAfter");
    chk("stallAfter.we", {31'd0, RegWEn_o}, 32'd0);

    // flush: no pulse, no count
    setInst(1, 1, 5'd7, 2'b01, 3'b010, 32'h01234567, 0, 0);
    flush_i = 1;
    cycle("flush1"); cycle("flush2");
    flush_i = 0; valid_i = 0;
    cycle("flushAfter");

    // async reset during a write pulse
    setInst(1, 1, 5'd3, 2'b01, 3'b010, 32'hCAFEF00D, 0, 0);
    @(posedge clk_i);
    modelEdge();
    #1 checkAll("preRst");
    #2 rst_i = 1'b1;
    modelReset();
    #1 checkAll("midRst");
    @(negedge clk_i);
    valid_i = 0;
    @(negedge clk_i);
    rst_i = 1'b0;
    cycle("postRst");

    // counter wrap: preload the count, then one capture
    force dut.instRet_p0 = 32'hFFFFFFFF;
    #1 release dut.instRet_p0;
    mCnt = 32'hFFFFFFFF;
    setInst(1, 1, 5'd4, 2'b01, 3'b010, 32'h11111111, 0, 0);
    cycle("wrap");
    chk("wrap.const", InstRet_o, 32'd0);

    // randomized traffic against the reference model
    for (int i = 0; i < 300; i++) begin
      valid_i   = ($urandom_range(0, 3) != 0);
      stall_i   = ($urandom_range(0, 4) == 0);
      flush_i   = ($urandom_range(0, 6) == 0);
      RegWEn_i  = $urandom_range(0, 1) == 1;
      AddrD_i   = 5'($urandom);
      WBSel_i   = 2'($urandom);
      Funct3_i  = 3'($urandom);
      ALURes_i  = $urandom;
      MemData_i = $urandom;
      PC_i      = ($urandom_range(0, 9) == 0) ? 32'hFFFFFFFC : $urandom;
      cycle("rand");
    end

    $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
    $finish;
  end

endmodule
